// File: rtl/button_debouncer.sv
// button_debouncer: raw push-button pins -> clean, clock-synchronous levels.
// Each bit goes through a 2-flop synchroniser and then its own stability
// counter. A new level is committed only after it has disagreed with the
// current output for STABLE_CYCLES consecutive cycles.
//
// Optional feature macro: DEBOUNCE_EDGE_EN
//   defined   -> adds output pressed[WIDTH-1:0], a registered one-cycle pulse
//                on the cycle after a bit of buttons commits 0->1.
//   undefined -> no pressed port and no edge logic.

// Per-bit stability counter: commits sync_in to level after a full run of
// STABLE_CYCLES disagreeing cycles. Any agreement restarts the run from zero.
module debounce_bit #(
    parameter int unsigned STABLE_CYCLES = 120000,
    parameter int unsigned CNT_W         = 17
) (
    input  logic clk,
    input  logic reset,
    input  logic sync_in,
    output logic level
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Count disagreement cycles; commit and clear on the last one.
    // The counter stops at LAST, so it can never wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync_in == level) begin
            cnt   <= '0;
        end else if (cnt == LAST) begin
            level <= sync_in;
            cnt   <= '0;
        end else begin
            cnt   <= cnt + CNT_W'(1);
        end
    end
endmodule

module button_debouncer #(
    parameter int unsigned WIDTH         = 3,
    parameter int unsigned STABLE_CYCLES = 120000,
    parameter int unsigned ACTIVE_LOW    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] buttons_raw,
    output logic [WIDTH-1:0] buttons
`ifdef DEBOUNCE_EDGE_EN
    ,
    output logic [WIDTH-1:0] pressed
`endif
);
    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

    logic [WIDTH-1:0] in_n;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    // Normalise polarity so that everything downstream sees 1 = pressed.
    assign in_n = (ACTIVE_LOW != 0) ? ~buttons_raw : buttons_raw;

    // Two-flop synchroniser; only s2 is consumed by the counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= in_n;
            s2 <= s1;
        end
    end

    // One independent stability counter per button.
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_bit (
            .clk     (clk),
            .reset   (reset),
            .sync_in (s2[g]),
            .level   (buttons[g])
        );
    end

`ifdef DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] buttons_d;

    // Rising-edge detect on the committed level; release gives no pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            buttons_d <= '0;
            pressed   <= '0;
        end else begin
            buttons_d <= buttons;
            pressed   <= buttons & ~buttons_d;
        end
    end
`endif
endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer. Three instances: S=4 active-high, S=4
// active-low, and S=1 active-high (shares pins with the first). A window-rule
// reference model predicts every output after every edge.
module tb_button_debouncer;
    localparam int W    = 3;
    localparam int MAXE = 4096;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] raw0, raw1;
    logic [W-1:0] b0, b1, b2;
`ifdef DEBOUNCE_EDGE_EN
    logic [W-1:0] p0, p1, p2;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    button_debouncer #(.WIDTH(W), .STABLE_CYCLES(4), .ACTIVE_LOW(0)) dut0 (
        .clk(clk), .reset(reset), .buttons_raw(raw0), .buttons(b0)
`ifdef DEBOUNCE_EDGE_EN
        , .pressed(p0)
`endif
    );
    button_debouncer #(.WIDTH(W), .STABLE_CYCLES(4), .ACTIVE_LOW(1)) dut1 (
        .clk(clk), .reset(reset), .buttons_raw(raw1), .buttons(b1)
`ifdef DEBOUNCE_EDGE_EN
        , .pressed(p1)
`endif
    );
    button_debouncer #(.WIDTH(W), .STABLE_CYCLES(1), .ACTIVE_LOW(0)) dut2 (
        .clk(clk), .reset(reset), .buttons_raw(raw0), .buttons(b2)
`ifdef DEBOUNCE_EDGE_EN
        , .pressed(p2)
`endif
    );

    // ---------------- reference model ----------------
    // The pressed-level seen by the counters at edge t is the pin value
    // sampled at edge t-2 (zero if that sample predates the last reset).
    // A bit flips at edge t when the S most recent such values, all taken
    // after the last reset, disagree with the current output.
    int           s_of [3] = '{4, 4, 1};
    bit [W-1:0]   inh  [3][MAXE];
    bit [W-1:0]   oh   [3][MAXE];
    bit [W-1:0]   exp_b [3];
    bit [W-1:0]   exp_p [3];
    int           e = 0;
    int           last_rst = 0;

    always @(posedge clk) begin
        bit [W-1:0] prev, nxt;
        bit         flip, sv;
        int         t;
        e = e + 1;
        if (e >= MAXE) $fatal(1, "FAIL model_overflow edge budget exceeded");
        inh[0][e] = raw0;
        inh[1][e] = ~raw1;
        inh[2][e] = raw0;
        if (reset) last_rst = e;
        for (int m = 0; m < 3; m++) begin
            if (reset) begin
                oh[m][e] = '0;
                exp_p[m] = '0;
            end else begin
                prev = oh[m][e-1];
                nxt  = prev;
                for (int b = 0; b < W; b++) begin
                    flip = 1'b1;
                    for (int j = 0; j < s_of[m]; j++) begin
                        t = e - j;
                        if (t <= last_rst) flip = 1'b0;
                        else begin
                            sv = (t - 2 > last_rst) ? inh[m][t-2][b] : 1'b0;
                            if (sv == prev[b]) flip = 1'b0;
                        end
                    end
                    if (flip) nxt[b] = ~prev[b];
                end
                oh[m][e] = nxt;
                exp_p[m] = (e >= 2) ? (oh[m][e-1] & ~oh[m][e-2]) : '0;
            end
            exp_b[m] = oh[m][e];
        end
    end

    // ---------------- tests ----------------
    // Reset held with all buttons pressed; first commit 5 edges after the
    // first edge that samples reset low.
    task automatic test_reset();
        reset = 1'b1; raw0 = 3'b111; raw1 = 3'b000;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({b0, b1, b2} !== 9'b0) begin
                errors++; $display("FAIL reset_hold got %b_%b_%b exp 0", b0, b1, b2);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (b0 !== ((i >= 5) ? 3'b111 : 3'b000)) begin
                errors++; $display("FAIL reset_release i=%0d got %b exp %b", i, b0, (i >= 5) ? 3'b111 : 3'b000);
            end
            checks++;
            if ({b0, b1, b2} !== {exp_b[0], exp_b[1], exp_b[2]}) begin
                errors++; $display("FAIL model_reset got %h exp %h", {b0, b1, b2}, {exp_b[0], exp_b[1], exp_b[2]});
            end
        end
    endtask

    task automatic settle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if ({b0, b1, b2} !== {exp_b[0], exp_b[1], exp_b[2]}) begin
                errors++; $display("FAIL model_%s got %h exp %h", tag, {b0, b1, b2}, {exp_b[0], exp_b[1], exp_b[2]});
            end
        end
    endtask

    task automatic test_single_rise();
        raw0 = 3'b000;
        settle("settle0", 12);
        raw0 = 3'b001;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (b0 !== ((i >= 5) ? 3'b001 : 3'b000)) begin
                errors++; $display("FAIL single_rise i=%0d got %b exp %b", i, b0, (i >= 5) ? 3'b001 : 3'b000);
            end
            checks++;
            if ({b0, b1, b2} !== {exp_b[0], exp_b[1], exp_b[2]}) begin
                errors++; $display("FAIL model_rise got %h exp %h", {b0, b1, b2}, {exp_b[0], exp_b[1], exp_b[2]});
            end
        end
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 14; i++) begin
            raw0[1] = (i < 3);
            @(negedge clk);
            checks++;
            if (b0[1] !== 1'b0) begin
                errors++; $display("FAIL glitch i=%0d got %b exp 0", i, b0[1]);
            end
            checks++;
            if ({b0, b1, b2} !== {exp_b[0], exp_b[1], exp_b[2]}) begin
                errors++; $display("FAIL model_glitch got %h exp %h", {b0, b1, b2}, {exp_b[0], exp_b[1], exp_b[2]});
            end
        end
    endtask

    task automatic test_bounce();
        bit [4:0] seq = 5'b10101;
        int       rises = 0;
        bit       last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            raw0[2] = seq[4-i];
            @(negedge clk);
            checks++;
            if (b0[2] !== 1'b0) begin
                errors++; $display("FAIL bounce_early i=%0d got %b exp 0", i, b0[2]);
            end
        end
        raw0[2] = seq[0];
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (b0[2] && !last) rises++;
            last = b0[2];
            checks++;
            if (b0[2] !== (i >= 5)) begin
                errors++; $display("FAIL bounce_commit i=%0d got %b exp %b", i, b0[2], i >= 5);
            end
        end
        checks++;
        if (rises !== 1) begin
            errors++; $display("FAIL bounce_once got %0d rises exp 1", rises);
        end
    endtask

    task automatic test_reset_mid();
        checks++;
        if (b0 !== 3'b101) begin
            errors++; $display("FAIL reset_mid_pre got %b exp 101", b0);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({b0, b1, b2} !== 9'b0) begin
            errors++; $display("FAIL reset_mid_clear got %b_%b_%b exp 0", b0, b1, b2);
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (b0 !== ((i >= 5) ? 3'b101 : 3'b000)) begin
                errors++; $display("FAIL reset_mid_recommit i=%0d got %b exp %b", i, b0, (i >= 5) ? 3'b101 : 3'b000);
            end
        end
    endtask

    task automatic test_active_low();
        raw1 = 3'b111;
        settle("al_settle", 12);
        raw1 = 3'b110;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (b1 !== ((i >= 5) ? 3'b001 : 3'b000)) begin
                errors++; $display("FAIL active_low i=%0d got %b exp %b", i, b1, (i >= 5) ? 3'b001 : 3'b000);
            end
`ifdef DEBOUNCE_EDGE_EN
            checks++;
            if (p1 !== ((i == 6) ? 3'b001 : 3'b000)) begin
                errors++; $display("FAIL pressed_pulse i=%0d got %b exp %b", i, p1, (i == 6) ? 3'b001 : 3'b000);
            end
`endif
        end
        raw1 = 3'b111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (b1 !== ((i >= 5) ? 3'b000 : 3'b001)) begin
                errors++; $display("FAIL release i=%0d got %b exp %b", i, b1, (i >= 5) ? 3'b000 : 3'b001);
            end
`ifdef DEBOUNCE_EDGE_EN
            checks++;
            if (p1 !== 3'b000) begin
                errors++; $display("FAIL release_pulse i=%0d got %b exp 000", i, p1);
            end
`endif
        end
    endtask

    task automatic test_random();
        int hold0 = 0, hold1 = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold0 == 0) begin
                raw0 = W'($urandom); hold0 = $urandom_range(1, 7);
            end
            if (hold1 == 0) begin
                raw1 = W'($urandom); hold1 = $urandom_range(1, 7);
            end
            hold0--; hold1--;
            reset = ($urandom_range(0, 79) == 0);
            @(negedge clk);
            checks++;
            if ({b0, b1, b2} !== {exp_b[0], exp_b[1], exp_b[2]}) begin
                errors++; $display("FAIL model_random i=%0d got %h exp %h", i, {b0, b1, b2}, {exp_b[0], exp_b[1], exp_b[2]});
            end
`ifdef DEBOUNCE_EDGE_EN
            checks++;
            if ({p0, p1, p2} !== {exp_p[0], exp_p[1], exp_p[2]}) begin
                errors++; $display("FAIL model_pressed i=%0d got %h exp %h", i, {p0, p1, p2}, {exp_p[0], exp_p[1], exp_p[2]});
            end
`endif
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; raw0 = 3'b111; raw1 = 3'b000;
        test_reset();
        test_single_rise();
        test_glitch();
        test_bounce();
        test_reset_mid();
        test_active_low();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
